// File: rtl/maquina_vend_ctrl.sv
// Multi-product coin vending controller: edge-detected coin/buy/return inputs,
// per-product pricing, timed vend strobe and greedy change returned as coin pulses.
module maquina_vend_ctrl #(
  parameter int N_PROD      = 4,
  parameter int CREDIT_W    = 8,
  parameter int NICKEL_VAL  = 5,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICE_LIST = {8'd50, 8'd40, 8'd30, 8'd25},
  parameter int CREDIT_MAX  = 200,
  parameter int VEND_CYC    = 4,
  localparam int PSEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                coin_q,
  input  logic                buy,
  input  logic [PSEL_W-1:0]   prod_sel,
  input  logic                ret,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   vend,
  output logic                chg_q,
  output logic                chg_d,
  output logic                chg_n,
  output logic                coin_reject,
  output logic                err_insuf,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  localparam int VCNT_W = (VEND_CYC > 1) ? $clog2(VEND_CYC) : 1;
  localparam logic [CREDIT_W-1:0] NICKEL  = CREDIT_W'(NICKEL_VAL);
  localparam logic [CREDIT_W-1:0] DIME    = CREDIT_W'(DIME_VAL);
  localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(QUARTER_VAL);
  localparam logic [CREDIT_W:0]   CMAX    = (CREDIT_W+1)'(CREDIT_MAX);

  // Input order in the edge registers: {ret, buy, coin_q, coin_d, coin_n}
  logic [4:0]        lvl_r, lvl_p, evt;
  logic [PSEL_W-1:0] psel_r;

  // Edge registers come out of reset high so a level already asserted at
  // release is not mistaken for a fresh event. prod_sel is registered alongside
  // so it lines up with the buy edge it belongs to.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_r  <= '1;
      lvl_p  <= '1;
      psel_r <= '0;
    end else begin
      lvl_r  <= {ret, buy, coin_q, coin_d, coin_n};
      lvl_p  <= lvl_r;
      psel_r <= prod_sel;
    end
  end

  assign evt = lvl_r & ~lvl_p;

  logic       ret_evt, buy_evt, any_coin, multi_coin;
  logic [2:0] coin_evt;
  assign ret_evt    = evt[4];
  assign buy_evt    = evt[3];
  assign coin_evt   = evt[2:0];
  assign any_coin   = |coin_evt;
  assign multi_coin = (coin_evt & (coin_evt - 3'd1)) != 3'd0;

  state_t                state, state_nxt;
  logic [CREDIT_W-1:0]   credit_nxt;
  logic [N_PROD-1:0]     vend_nxt;
  logic                  chg_q_nxt, chg_d_nxt, chg_n_nxt;
  logic                  coin_reject_nxt, err_insuf_nxt, busy_nxt;
  logic [VCNT_W-1:0]     vcnt, vcnt_nxt;
  logic                  gap, gap_nxt;
  logic                  start_chg;

  logic [CREDIT_W-1:0]   coin_val, price, g_val;
  logic [CREDIT_W:0]     coin_sum;
  logic [N_PROD-1:0]     vend_sel;
  logic                  sel_ok;
  logic [2:0]            g_coin;

  // NOTE: every combinational output gets a default before any branch so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    coin_val = NICKEL;
    if (coin_evt[2])      coin_val = QUARTER;
    else if (coin_evt[1]) coin_val = DIME;
  end

  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

  // Out-of-range selections never match, leaving sel_ok low.
  always_comb begin
    price    = '0;
    sel_ok   = 1'b0;
    vend_sel = '0;
    for (int k = 0; k < N_PROD; k++) begin
      if (psel_r == PSEL_W'(k)) begin
        price       = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
        sel_ok      = 1'b1;
        vend_sel[k] = 1'b1;
      end
    end
  end

  // Largest coin not exceeding the remaining credit, as {q, d, n}.
  always_comb begin
    g_coin = 3'b001;
    g_val  = NICKEL;
    if (credit >= QUARTER) begin
      g_coin = 3'b100;
      g_val  = QUARTER;
    end else if (credit >= DIME) begin
      g_coin = 3'b010;
      g_val  = DIME;
    end
  end

  always_comb begin
    state_nxt       = state;
    credit_nxt      = credit;
    vend_nxt        = vend;
    vcnt_nxt        = vcnt;
    gap_nxt         = gap;
    chg_q_nxt       = 1'b0;
    chg_d_nxt       = 1'b0;
    chg_n_nxt       = 1'b0;
    coin_reject_nxt = 1'b0;
    err_insuf_nxt   = 1'b0;
    start_chg       = 1'b0;

    unique case (state)
      IDLE: begin
        if (ret_evt && credit != '0) begin
          start_chg       = 1'b1;
          coin_reject_nxt = any_coin;
        end else if (buy_evt) begin
          coin_reject_nxt = any_coin;
          if (sel_ok && credit >= price) begin
            credit_nxt = credit - price;
            vend_nxt   = vend_sel;
            vcnt_nxt   = VCNT_W'(VEND_CYC - 1);
            state_nxt  = VEND;
          end else begin
            err_insuf_nxt = 1'b1;
          end
        end else if (any_coin) begin
          if (multi_coin || coin_sum > CMAX) coin_reject_nxt = 1'b1;
          else                               credit_nxt = coin_sum[CREDIT_W-1:0];
        end
      end

      VEND: begin
        coin_reject_nxt = any_coin;
        if (vcnt == '0) begin
          vend_nxt = '0;
          if (credit != '0) start_chg = 1'b1;
          else              state_nxt = IDLE;
        end else begin
          vcnt_nxt = vcnt - VCNT_W'(1);
        end
      end

      CHANGE: begin
        coin_reject_nxt = any_coin;
        if (!gap)                gap_nxt   = 1'b1;
        else if (credit == '0)   state_nxt = IDLE;
        else                     start_chg = 1'b1;
      end

      default: state_nxt = IDLE;
    endcase

    // Pulse cycle: the coin output and the credit debit land on the same edge.
    if (start_chg) begin
      state_nxt                           = CHANGE;
      gap_nxt                             = 1'b0;
      {chg_q_nxt, chg_d_nxt, chg_n_nxt}   = g_coin;
      credit_nxt                          = credit - g_val;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      credit      <= '0;
      vend        <= '0;
      vcnt        <= '0;
      gap         <= 1'b0;
      chg_q       <= 1'b0;
      chg_d       <= 1'b0;
      chg_n       <= 1'b0;
      coin_reject <= 1'b0;
      err_insuf   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      vend        <= vend_nxt;
      vcnt        <= vcnt_nxt;
      gap         <= gap_nxt;
      chg_q       <= chg_q_nxt;
      chg_d       <= chg_d_nxt;
      chg_n       <= chg_n_nxt;
      coin_reject <= coin_reject_nxt;
      err_insuf   <= err_insuf_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: doc/maquina_vend_ctrl.md
# maquina_vend_ctrl

Parametrised coin-operated vending controller, next generation of the single-product machine behind the board's P/R/N/D switches. Accepts nickel/dime/quarter inserts, sells one of N_PROD products at individually configured prices, and returns change greedily as discrete coin pulses. It sits directly behind the debounced switch inputs and drives dispense/change LEDs or actuators.

## Interface
- N_PROD, 4: number of products; prod_sel width is $clog2(N_PROD) (min 1).
- CREDIT_W, 8: credit register width.
- NICKEL_VAL, 5 / DIME_VAL, 10 / QUARTER_VAL, 25: coin values.
- PRICE_LIST, {8'd50,8'd40,8'd30,8'd25}: packed N_PROD*CREDIT_W; slice k is the price of product k. All prices must be multiples of NICKEL_VAL.
- CREDIT_MAX, 200: credit ceiling; CREDIT_MAX+QUARTER_VAL < 2**CREDIT_W.
- VEND_CYC, 4: cycles the vend output is held.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- coin_n, coin_d, coin_q  in  1 each  coin-insert levels (debounced upstream).
- buy  in  1  purchase request level.
- prod_sel  in  $clog2(N_PROD)  product index, sampled on the buy event.
- ret  in  1  return-credit request level.
- credit  out  CREDIT_W  current credit.
- vend  out  N_PROD  one-hot dispense strobe.
- chg_q, chg_d, chg_n  out  1 each  change-coin pulses.
- coin_reject  out  1  1-cycle pulse: inserted coin not accepted.
- err_insuf  out  1  1-cycle pulse: buy with insufficient credit.
- busy  out  1  high in VEND and CHANGE.

## Operation
- Each level input is rising-edge detected internally. Edge registers reset to 1, so an input already high at reset release is not an event.
- States: IDLE, VEND, CHANGE. All outputs are registered.
- IDLE event priority in one cycle is ret > buy > coin.
  - Any coin edge in the same cycle as an accepted ret/buy is dropped and pulses coin_reject.
  - Two or more simultaneous coin edges: all rejected (coin_reject), credit unchanged.
- Coin: if credit+value > CREDIT_MAX, pulse coin_reject and leave credit unchanged; else credit += value.
- buy: if credit >= PRICE_LIST[prod_sel], credit -= price, vend[prod_sel]=1, go to VEND. Else pulse err_insuf, stay IDLE, credit unchanged. prod_sel >= N_PROD is treated as insufficient (err_insuf).
- ret: go to CHANGE if credit > 0; else ignored.
- VEND: vend is held VEND_CYC cycles. Then go to CHANGE if credit > 0, else IDLE.
- CHANGE: greedy dispense, alternating a pulse cycle with a gap cycle.
  - Pulse cycle: assert chg_q if credit >= QUARTER_VAL, else chg_d if credit >= DIME_VAL, else chg_n. Credit decreases by that coin's value at the same edge.
  - Gap cycle: all chg low.
  - After the gap that follows the pulse bringing credit to 0, return to IDLE.
- In VEND/CHANGE: coin edges pulse coin_reject; buy/ret are ignored.
- Reset at any time clears state to IDLE and zeroes all outputs. In-flight vend and remaining change are lost.

## Timing
- Reset values: credit=0, vend=0, chg_*=0, coin_reject=0, err_insuf=0, busy=0, state IDLE.
- Latency: input first sampled high at edge t drives credit, vend, busy, coin_reject and err_insuf valid after edge t+1.
- vend is high for exactly VEND_CYC cycles. The first change pulse occurs the cycle after vend drops.
- Each change coin takes 2 cycles; returning credit C costs 2 × (number of greedy coins) cycles.
- busy is asserted together with vend or the first change pulse, and deasserts the cycle state returns to IDLE.
- A new edge requires its input to go low for at least one cycle.

## Test plan
- Reset, insert N, D, Q in turn -> credit 5, 15, 40; no coin_reject.
- credit 40, prod_sel=1, buy -> vend=4'b0010 for 4 cycles, credit 10, then one chg_d pulse, credit 0, busy low, IDLE.
- credit 25, prod_sel=3, buy -> err_insuf for 1 cycle, credit stays 25, vend 0.
- credit 190, insert Q -> coin_reject 1 cycle, credit 190. Insert D -> credit 200.
- credit 65, ret -> pulse sequence chg_q, chg_q, chg_d, chg_n, each 1 high/1 low; credit 40, 15, 5, 0; busy high for 8 cycles.
- Boundary cases:
  - ret and coin_q edges in the same cycle -> coin_reject, CHANGE entered with the old credit.
  - coin_d and coin_n edges together -> coin_reject, credit unchanged.
  - Reset asserted mid-CHANGE -> all outputs 0 immediately.
  - coin_q held high through reset release -> no credit.
